// File: rtl/alu_pkg.sv
// Shared opcode, shift-mode and FSM definitions for the multicycle ALU.
package alu_pkg;

    localparam logic [2:0] OP_FWD   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_SLL   = 3'd4;
    localparam logic [2:0] OP_RIGHT = 3'd5;
    localparam logic [2:0] OP_MULT  = 3'd6;
    localparam logic [2:0] OP_SUB   = 3'd7;

    // Right-shift mode lives in the top two bits of DATA2; any 1x pattern rotates.
    localparam logic [1:0] SR_LOGIC = 2'b00;
    localparam logic [1:0] SR_ARITH = 2'b01;
    localparam logic [1:0] SR_ROT   = 2'b10;

    typedef enum logic [0:0] {
        IDLE,
        MUL
    } state_e;

endpackage

// File: rtl/alu_if.sv
// Request/response bundle between the CPU control path and the multicycle ALU.
interface alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [2:0]       select;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, select, data1, data2,
        input  result, zero, carry, overflow, busy, done
    );

    modport slave (
        input  start, select, data1, data2,
        output result, zero, carry, overflow, busy, done
    );
endinterface

// File: rtl/seq_mult.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH iterations per load.
module seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    always_comb begin
        acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
    end

    // product is the accumulator value the final iteration is about to write, so the
    // caller can register it on the same edge that completes the multiply.
    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign busy    = busy_q;
    assign product = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (load) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU: single-cycle ops finish in one clock, MULT iterates WIDTH cycles.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic  clk,
    input logic  rst_n,
    alu_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    state_e state_q, state_d;

    logic [WIDTH-1:0]   a, b;
    logic [SHW-1:0]     amt;
    logic [1:0]         mode;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] sll_ext, srl_ext, sra_ext, rot_ext;
    logic [WIDTH-1:0]   alu_res, res_d, result_q;
    logic               alu_c, alu_v, c_d, v_d, upd;
    logic               zero_q, carry_q, ovf_q, done_q;
    logic               mult_load, mult_busy, mult_done;
    logic [2*WIDTH-1:0] product;

    assign a    = bus.data1;
    assign b    = bus.data2;
    assign amt  = b[SHW-1:0];
    assign mode = b[WIDTH-1 -: 2];

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        // Widened shifts keep the last bit pushed out next to the result.
        sll_ext = {{WIDTH{1'b0}}, a} << amt;
        srl_ext = {a, {WIDTH{1'b0}}} >> amt;
        sra_ext = $signed({a, {WIDTH{1'b0}}}) >>> amt;
        rot_ext = {a, a} >> amt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.select)
            OP_FWD: alu_res = b;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_SLL: begin
                alu_res = sll_ext[WIDTH-1:0];
                alu_c   = sll_ext[WIDTH];
            end
            OP_RIGHT: begin
                if (mode == SR_LOGIC) begin
                    alu_res = srl_ext[2*WIDTH-1:WIDTH];
                    alu_c   = srl_ext[WIDTH-1];
                end else if (mode == SR_ARITH) begin
                    alu_res = sra_ext[2*WIDTH-1:WIDTH];
                    alu_c   = sra_ext[WIDTH-1];
                end else begin
                    alu_res = rot_ext[WIDTH-1:0];
                    alu_c   = (amt != '0) && rot_ext[WIDTH-1];
                end
            end
            default: ;
        endcase
    end

    seq_mult #(
        .WIDTH(WIDTH)
    ) u_seq_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mult_load),
        .a      (a),
        .b      (b),
        .busy   (mult_busy),
        .done   (mult_done),
        .product(product)
    );

    always_comb begin
        state_d   = state_q;
        mult_load = 1'b0;
        upd       = 1'b0;
        res_d     = alu_res;
        c_d       = alu_c;
        v_d       = alu_v;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.select == OP_MULT) begin
                        mult_load = 1'b1;
                        state_d   = MUL;
                    end else begin
                        upd = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mult_busy && mult_done) begin
                    upd     = 1'b1;
                    res_d   = product[WIDTH-1:0];
                    c_d     = 1'b0;
                    v_d     = |product[2*WIDTH-1:WIDTH];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= upd;
            if (upd) begin
                result_q <= res_d;
                zero_q   <= (res_d == '0);
                carry_q  <= c_d;
                ovf_q    <= v_d;
            end
        end
    end

    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q == MUL);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH 8 and 16.
module tb_multicycle_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alu_if #(.WIDTH(8))  bus8 ();
    alu_if #(.WIDTH(16)) bus16 ();

    multicycle_alu #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus8)
    );

    multicycle_alu #(.WIDTH(16)) dut16 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    // Drive one 8-bit request for one clock; returns 1 time unit after the sampling edge.
    task automatic op8(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus8.start  = 1'b1;
        bus8.select = sel;
        bus8.data1  = a;
        bus8.data2  = b;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus8.start   = 1'b0;
        bus8.select  = '0;
        bus8.data1   = '0;
        bus8.data2   = '0;
        bus16.start  = 1'b0;
        bus16.select = '0;
        bus16.data1  = '0;
        bus16.data2  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus8.result, bus8.zero, bus8.carry, bus8.overflow, bus8.busy, bus8.done}
            !== {8'h00, 5'b10000}) begin
            errors++;
            $display("FAIL reset8: got r=%h z%b c%b v%b b%b d%b, want r=00 z1 c0 v0 b0 d0",
                     bus8.result, bus8.zero, bus8.carry, bus8.overflow, bus8.busy, bus8.done);
        end
        checks++;
        if ({bus16.result, bus16.zero, bus16.busy, bus16.done} !== {16'h0000, 3'b100}) begin
            errors++;
            $display("FAIL reset16: got r=%h z%b b%b d%b, want r=0000 z1 b0 d0",
                     bus16.result, bus16.zero, bus16.busy, bus16.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Entry layout: {sel[29:27], a[26:19], b[18:11], result[10:3], zero, carry, overflow}.
    task automatic test_arith_logic();
        logic [29:0] vec [8];
        vec = '{{OP_ADD, 8'h7F, 8'h01, 8'h80, 3'b001},
                {OP_ADD, 8'hFF, 8'h01, 8'h00, 3'b110},
                {OP_SUB, 8'h03, 8'h05, 8'hFE, 3'b010},
                {OP_SUB, 8'h80, 8'h01, 8'h7F, 3'b001},
                {OP_AND, 8'hF0, 8'h3C, 8'h30, 3'b000},
                {OP_OR,  8'hF0, 8'h3C, 8'hFC, 3'b000},
                {OP_FWD, 8'h11, 8'h5A, 8'h5A, 3'b000},
                {OP_AND, 8'h0F, 8'hF0, 8'h00, 3'b100}};
        for (int i = 0; i < 8; i++) begin
            op8(vec[i][29:27], vec[i][26:19], vec[i][18:11]);
            checks++;
            if ({bus8.result, bus8.zero, bus8.carry, bus8.overflow, bus8.done}
                !== {vec[i][10:0], 1'b1}) begin
                errors++;
                $display("FAIL arith[%0d]: got r=%h zcv=%b%b%b d%b, want r=%h zcv=%b d1", i,
                         bus8.result, bus8.zero, bus8.carry, bus8.overflow, bus8.done,
                         vec[i][10:3], vec[i][2:0]);
            end
        end
    endtask

    task automatic test_shifts();
        logic [29:0] vec [8];
        vec = '{{OP_SLL,   8'h81, 8'h01, 8'h02, 3'b010},
                {OP_RIGHT, 8'h80, 8'h43, 8'hF0, 3'b000},
                {OP_RIGHT, 8'h01, 8'h81, 8'h80, 3'b010},
                {OP_SLL,   8'hA5, 8'h00, 8'hA5, 3'b000},
                {OP_RIGHT, 8'hA5, 8'h40, 8'hA5, 3'b000},
                {OP_RIGHT, 8'h81, 8'h01, 8'h40, 3'b010},
                {OP_SLL,   8'h01, 8'h0A, 8'h04, 3'b000},
                {OP_SLL,   8'h02, 8'h07, 8'h00, 3'b110}};
        for (int i = 0; i < 8; i++) begin
            op8(vec[i][29:27], vec[i][26:19], vec[i][18:11]);
            checks++;
            if ({bus8.result, bus8.zero, bus8.carry, bus8.overflow, bus8.done}
                !== {vec[i][10:0], 1'b1}) begin
                errors++;
                $display("FAIL shift[%0d]: got r=%h zcv=%b%b%b d%b, want r=%h zcv=%b d1", i,
                         bus8.result, bus8.zero, bus8.carry, bus8.overflow, bus8.done,
                         vec[i][10:3], vec[i][2:0]);
            end
        end
        op8(OP_RIGHT, 8'h03, 8'hC1);
        checks++;
        if ({bus8.result, bus8.carry} !== {8'h81, 1'b1}) begin
            errors++;
            $display("FAIL rot11: got r=%h c%b, want r=81 c1", bus8.result, bus8.carry);
        end
    endtask

    task automatic test_mult();
        logic [7:0] a_tab [2];
        logic [7:0] b_tab [2];
        logic [10:0] exp_tab [2];
        int lat;
        a_tab   = '{8'd12, 8'h10};
        b_tab   = '{8'd11, 8'h10};
        exp_tab = '{{8'h84, 3'b000}, {8'h00, 3'b101}};
        op8(OP_FWD, 8'h00, 8'h3C);
        for (int i = 0; i < 2; i++) begin
            op8(OP_MULT, a_tab[i], b_tab[i]);
            // Scramble inputs: the multiply must use the captured operands.
            bus8.data1 = 8'hFF;
            bus8.data2 = 8'hFF;
            checks++;
            if ({bus8.busy, bus8.done, bus8.result} !== {2'b10, (i == 0) ? 8'h3C : 8'h84}) begin
                errors++;
                $display("FAIL mult_start[%0d]: got b%b d%b r=%h, want b1 d0 r held", i,
                         bus8.busy, bus8.done, bus8.result);
            end
            lat = 0;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk);
                #1;
                if (bus8.done) begin
                    lat = k;
                    break;
                end
            end
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL mult_latency[%0d]: got %0d, want 8", i, lat);
            end
            checks++;
            if ({bus8.result, bus8.zero, bus8.carry, bus8.overflow, bus8.busy}
                !== {exp_tab[i], 1'b0}) begin
                errors++;
                $display("FAIL mult_result[%0d]: got r=%h zcv=%b%b%b b%b, want r=%h zcv=%b b0",
                         i, bus8.result, bus8.zero, bus8.carry, bus8.overflow, bus8.busy,
                         exp_tab[i][10:3], exp_tab[i][2:0]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus8.done !== 1'b0) begin
                errors++;
                $display("FAIL mult_done_pulse[%0d]: got d%b, want d0", i, bus8.done);
            end
        end
    endtask

    task automatic test_start_during_mult();
        int cnt;
        int lat;
        logic [7:0] res;
        cnt = 0;
        lat = 0;
        res = '0;
        op8(OP_MULT, 8'd7, 8'd9);
        bus8.start  = 1'b1;
        bus8.select = OP_ADD;
        bus8.data1  = 8'h01;
        bus8.data2  = 8'h01;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) bus8.start = 1'b0;
            if (bus8.done) begin
                cnt++;
                lat = k;
                res = bus8.result;
            end
        end
        checks++;
        if ({cnt, lat} !== {32'd1, 32'd8}) begin
            errors++;
            $display("FAIL busy_ignore: got %0d DONE at cycle %0d, want 1 DONE at cycle 8",
                     cnt, lat);
        end
        checks++;
        if (res !== 8'h3F) begin
            errors++;
            $display("FAIL busy_ignore_result: got %h, want 3f", res);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] sel [4];
        logic [7:0] a [4];
        logic [7:0] b [4];
        logic [8:0] exp [4];
        sel = '{OP_ADD, OP_SUB, OP_OR, OP_FWD};
        a   = '{8'h10, 8'h50, 8'h0F, 8'h77};
        b   = '{8'h20, 8'h08, 8'hF0, 8'h00};
        exp = '{{8'h30, 1'b0}, {8'h48, 1'b0}, {8'hFF, 1'b0}, {8'h00, 1'b1}};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus8.start  = 1'b1;
            bus8.select = sel[i];
            bus8.data1  = a[i];
            bus8.data2  = b[i];
            @(posedge clk);
            #1;
            checks++;
            if ({bus8.result, bus8.zero, bus8.done} !== {exp[i], 1'b1}) begin
                errors++;
                $display("FAIL b2b[%0d]: got r=%h z%b d%b, want r=%h z%b d1", i,
                         bus8.result, bus8.zero, bus8.done, exp[i][8:1], exp[i][0]);
            end
        end
        bus8.start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got d%b, want d0", bus8.done);
        end
    endtask

    task automatic test_reset_mid_mult();
        int cnt;
        cnt = 0;
        op8(OP_MULT, 8'd3, 8'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus8.busy, bus8.done, bus8.result} !== {2'b00, 8'h00}) begin
            errors++;
            $display("FAIL reset_abort: got b%b d%b r=%h, want b0 d0 r=00",
                     bus8.busy, bus8.done, bus8.result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus8.done) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d DONE pulses, want 0", cnt);
        end
    endtask

    task automatic test_mult16();
        int lat;
        lat = 0;
        @(negedge clk);
        bus16.start  = 1'b1;
        bus16.select = OP_MULT;
        bus16.data1  = 16'h0100;
        bus16.data2  = 16'h0100;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus16.done) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != 16) begin
            errors++;
            $display("FAIL mult16_latency: got %0d, want 16", lat);
        end
        checks++;
        if ({bus16.result, bus16.zero, bus16.carry, bus16.overflow} !== {16'h0000, 3'b101}) begin
            errors++;
            $display("FAIL mult16_result: got r=%h zcv=%b%b%b, want r=0000 zcv=101",
                     bus16.result, bus16.zero, bus16.carry, bus16.overflow);
        end
    endtask

    initial begin
        test_reset();
        test_arith_logic();
        test_shifts();
        test_mult();
        test_start_during_mult();
        test_back_to_back();
        test_reset_mid_mult();
        test_mult16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered successor to the CPU's 8-bit combinational ALU. Executes one operation per START request: single-cycle ops (forward, add, sub, and, or, shifts/rotate) complete in one clock; MULT runs as an iterative shift-add over WIDTH cycles. Results and flags are held in output registers until the next request. The block sits between the register file and the writeback stage; BUSY stalls the CPU control unit.

## Interface
- WIDTH, 8, datapath width; must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount field width; derived, not overridden.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only while BUSY = 0.
- SELECT  in  3  opcode: 0 FORWARD, 1 ADD, 2 AND, 3 OR, 4 SLL, 5 RIGHT (shift/rotate), 6 MULT, 7 SUB.
- DATA1  in  WIDTH  operand A.
- DATA2  in  WIDTH  operand B, or shift control for op 4/5.
- RESULT  out  WIDTH  registered result.
- ZERO  out  1  RESULT == 0.
- CARRY  out  1  carry / borrow / last bit shifted out.
- OVERFLOW  out  1  signed overflow (ADD/SUB) or product truncation (MULT).
- BUSY  out  1  multiply in progress.
- DONE  out  1  one-cycle pulse: RESULT and flags valid.

## Operation
- SELECT, DATA1 and DATA2 are captured on the edge that samples START. Later input changes have no effect on the operation in flight.
- FORWARD: RESULT = DATA2.
- ADD: RESULT = A+B mod 2^WIDTH; CARRY = carry-out; OVERFLOW = signed overflow.
- SUB: RESULT = A−B mod 2^WIDTH; CARRY = borrow (1 iff A < B unsigned); OVERFLOW = signed overflow.
- AND / OR: bitwise; CARRY = OVERFLOW = 0.
- SLL: shift amount = DATA2[SHW-1:0]; zeros shift in. CARRY = last bit shifted out, or 0 if the amount is 0.
- RIGHT: shift amount = DATA2[SHW-1:0]; mode = DATA2[WIDTH-1:WIDTH-2].
  - 00: logical shift right.
  - 01: arithmetic shift right.
  - 1x: rotate right.
  - CARRY = last bit shifted or rotated out, or 0 if the amount is 0.
- MULT: unsigned shift-add with a 2·WIDTH accumulator, one multiplier bit per cycle.
  - RESULT = low WIDTH bits of the product.
  - OVERFLOW = 1 iff the high WIDTH bits are non-zero.
  - CARRY = 0.
- ZERO is computed from the final RESULT for every opcode.
- FSM states: IDLE, MUL.
  - IDLE: START with SELECT ≠ 6 writes RESULT and flags, pulses DONE, and stays in IDLE.
  - IDLE: START with SELECT = 6 loads the operands, clears the accumulator and counter, and moves to MUL.
  - MUL: one iteration per cycle. After iteration WIDTH, writes RESULT and flags, pulses DONE, and returns to IDLE.
- START while BUSY = 1 is ignored and is not queued.
- Reset values: RESULT = 0, ZERO = 1, CARRY = 0, OVERFLOW = 0, BUSY = 0, DONE = 0, state = IDLE.
- Reset asserted mid-multiply aborts the operation immediately; no DONE is produced.

## Timing
- Single-cycle ops: START sampled at edge n; RESULT, flags and DONE are valid after edge n. Latency 1, throughput 1 op per cycle with back-to-back START.
- MULT: START sampled at edge n.
  - BUSY = 1 after edge n.
  - Iterations occur at edges n+1 … n+WIDTH.
  - After edge n+WIDTH: RESULT, flags and DONE are valid and BUSY = 0.
  - A new START is accepted at edge n+WIDTH+1 or later.
- DONE is high for exactly one cycle per accepted request.
- RESULT and flags hold between requests, including while a multiply is in progress; they update only when DONE rises.
- No combinational path from inputs to outputs.

## Structure
- Package alu_pkg holds:
  - the opcode localparams (OP_FWD … OP_SUB);
  - the shift-mode constants (SR_LOGIC, SR_ARITH, SR_ROT);
  - the FSM state typedef (IDLE, MUL).
- One sub-module, seq_mult (parameter WIDTH):
  - ports: load, busy, done, 2·WIDTH product;
  - owns the accumulator and iteration counter.
- multicycle_alu keeps the combinational single-cycle datapath, output registers and FSM.

## Test plan
- Reset: hold RESET = 0 for 3 cycles → RESULT = 0, ZERO = 1, BUSY = 0, DONE = 0; assert RESET again mid-MULT → BUSY falls immediately and no DONE follows.
- ADD/SUB (WIDTH = 8): 0x7F+0x01 → 0x80, OVERFLOW = 1, CARRY = 0. 0xFF+0x01 → 0x00, ZERO = 1, CARRY = 1. 0x03−0x05 → 0xFE, CARRY = 1.
- Shifts (WIDTH = 8): SLL 0x81 by 1 → 0x02, CARRY = 1. RIGHT 0x80 with DATA2 = 0x43 (arithmetic, shift 3) → 0xF0. RIGHT 0x01 with DATA2 = 0x81 (rotate, 1) → 0x80, CARRY = 1. Amount 0 → operand unchanged, CARRY = 0.
- MULT: 12×11 → 0x84, OVERFLOW = 0, DONE exactly 8 cycles after the START edge. 0x10×0x10 → 0x00, ZERO = 1, OVERFLOW = 1.
- Handshake: START with ADD during MULT → ignored, exactly one DONE (for the MULT). Four back-to-back single-cycle STARTs → four consecutive DONE pulses with matching results.
- WIDTH = 16 instance: 0x0100×0x0100 → 0x0000, OVERFLOW = 1, latency 16 cycles.
